// File: rtl/pulse_train_monitor.sv
// pulse_train_monitor
//   Brings an asynchronous pulse stream onto the system clock and checks it.
//   It reports a strobe for each rising edge, measures the high width of each
//   pulse, counts pulses per fixed window, flags glitches (pulses that are too
//   short) and flags a timeout when no rising edge arrives for too long.
//
// Ports
//   clock        system clock; all state changes on its rising edge
//   clear        asynchronous active-low reset
//   enable       while low, the measurement state stays idle; rise still works
//   pulse_in     asynchronous pulse stream under observation
//   rise         one-cycle strobe for each detected rising edge
//   pulse_count  number of pulses counted in the last completed window
//   count_valid  one-cycle strobe when pulse_count updates
//   last_width   high width, in cycles, of the last completed pulse
//   width_valid  one-cycle strobe when last_width updates
//   glitch       one-cycle strobe with width_valid when the width is < MIN_WIDTH
//   timeout      level; set after TIMEOUT cycles with no rise, cleared by a rise
//
// Width FSM
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for a synchronised rising edge
//   ST_HIGH | pulse is high; wcnt holds the cycles seen so far (max 255)

module pulse_train_monitor #(
    parameter int CNT_W      = 16,
    parameter int WIN_CYCLES = 64,
    parameter int MIN_WIDTH  = 2,
    parameter int TIMEOUT    = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic             pulse_in,
    output logic             rise,
    output logic [CNT_W-1:0] pulse_count,
    output logic             count_valid,
    output logic [7:0]       last_width,
    output logic             width_valid,
    output logic             glitch,
    output logic             timeout
);

    localparam int                WIN_W    = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
    localparam int                IDLE_W   = $clog2(TIMEOUT + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT);
    localparam logic [CNT_W-1:0]  ACC_MAX  = '1;
    localparam logic [7:0]        WCNT_MAX = 8'd255;
    localparam logic [7:0]        MIN_W8   = 8'(MIN_WIDTH);

    typedef enum logic {ST_IDLE, ST_HIGH} state_t;

    state_t            state_q, state_d;
    logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [7:0]        wcnt_q, wcnt_d;
    logic [WIN_W-1:0]  wincnt_q, wincnt_d;
    logic [CNT_W-1:0]  acc_q, acc_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic              rise_q, rise_d;
    logic [CNT_W-1:0]  pulse_count_q, pulse_count_d;
    logic              count_valid_q, count_valid_d;
    logic [7:0]        last_width_q, last_width_d;
    logic              width_valid_q, width_valid_d;
    logic              glitch_q, glitch_d;
    logic              timeout_q, timeout_d;

    logic              edge_r, edge_f;
    logic [CNT_W-1:0]  acc_inc;

    always_comb begin
        s1_d          = pulse_in;
        s2_d          = s1_q;
        s3_d          = s2_q;
        edge_r        = s2_q & ~s3_q;
        edge_f        = ~s2_q & s3_q;

        state_d       = state_q;
        wcnt_d        = wcnt_q;
        wincnt_d      = wincnt_q;
        acc_d         = acc_q;
        idle_d        = idle_q;
        rise_d        = edge_r;
        pulse_count_d = pulse_count_q;
        count_valid_d = 1'b0;
        last_width_d  = last_width_q;
        width_valid_d = 1'b0;
        glitch_d      = 1'b0;
        timeout_d     = timeout_q;

        // Accumulator including a rise seen this cycle, so a rise on the last
        // window cycle lands in the closing window, not the next one.
        acc_inc = (edge_r && (acc_q != ACC_MAX)) ? acc_q + CNT_W'(1) : acc_q;

        if (!enable) begin
            state_d   = ST_IDLE;
            wcnt_d    = '0;
            wincnt_d  = '0;
            acc_d     = '0;
            idle_d    = '0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (edge_r) begin
                        state_d = ST_HIGH;
                        wcnt_d  = 8'd1;
                    end
                end
                ST_HIGH: begin
                    if (edge_f) begin
                        last_width_d  = wcnt_q;
                        width_valid_d = 1'b1;
                        glitch_d      = (wcnt_q < MIN_W8);
                        state_d       = ST_IDLE;
                        wcnt_d        = '0;
                    end else if (s2_q && (wcnt_q != WCNT_MAX)) begin
                        wcnt_d = wcnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                end
            endcase

            if (wincnt_q == WIN_LAST) begin
                pulse_count_d = acc_inc;
                count_valid_d = 1'b1;
                wincnt_d      = '0;
                acc_d         = '0;
            end else begin
                wincnt_d = wincnt_q + WIN_W'(1);
                acc_d    = acc_inc;
            end

            // A rise beats the counter reaching TIMEOUT in the same cycle.
            if (edge_r) begin
                idle_d    = '0;
                timeout_d = 1'b0;
            end else begin
                idle_d    = (idle_q == IDLE_MAX) ? idle_q : idle_q + IDLE_W'(1);
                timeout_d = (idle_d == IDLE_MAX);
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q       <= ST_IDLE;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            wcnt_q        <= '0;
            wincnt_q      <= '0;
            acc_q         <= '0;
            idle_q        <= '0;
            rise_q        <= 1'b0;
            pulse_count_q <= '0;
            count_valid_q <= 1'b0;
            last_width_q  <= '0;
            width_valid_q <= 1'b0;
            glitch_q      <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            wcnt_q        <= wcnt_d;
            wincnt_q      <= wincnt_d;
            acc_q         <= acc_d;
            idle_q        <= idle_d;
            rise_q        <= rise_d;
            pulse_count_q <= pulse_count_d;
            count_valid_q <= count_valid_d;
            last_width_q  <= last_width_d;
            width_valid_q <= width_valid_d;
            glitch_q      <= glitch_d;
            timeout_q     <= timeout_d;
        end
    end

    assign rise        = rise_q;
    assign pulse_count = pulse_count_q;
    assign count_valid = count_valid_q;
    assign last_width  = last_width_q;
    assign width_valid = width_valid_q;
    assign glitch      = glitch_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_pulse_train_monitor.sv
module tb_pulse_train_monitor;

    logic        clock;
    logic        clear;
    logic        enable;
    logic        pulse_in;
    logic        rise;
    logic [15:0] pulse_count;
    logic        count_valid;
    logic [7:0]  last_width;
    logic        width_valid;
    logic        glitch;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int         hi;
        int         lo;
        logic [7:0] exp_w;
        logic       exp_g;
    } vec_t;

    typedef struct {
        logic [7:0] w;
        logic       g;
    } wexp_t;

    vec_t        vecs[6];
    wexp_t       wq[$];
    logic [15:0] cq[$];
    wexp_t       mon_e;
    logic [15:0] mon_c;
    logic        chk_width = 1'b0;
    logic        chk_count = 1'b0;
    int          rises;

    pulse_train_monitor #(
        .CNT_W(16), .WIN_CYCLES(64), .MIN_WIDTH(2), .TIMEOUT(32)
    ) dut (
        .clock(clock), .clear(clear), .enable(enable), .pulse_in(pulse_in),
        .rise(rise), .pulse_count(pulse_count), .count_valid(count_valid),
        .last_width(last_width), .width_valid(width_valid), .glitch(glitch),
        .timeout(timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_pulse(input int hi, input int lo);
        pulse_in = 1'b1;
        repeat (hi) tick();
        pulse_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic do_reset();
        clear = 1'b0;
        #2;
        clear = 1'b1;
    endtask

    // Scoreboard: strobes pop the expectations pushed by the stimulus.
    always @(negedge clock) begin
        if (chk_width && width_valid) begin
            if (wq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL width_unexpected last_width=%0d required=no_event", last_width);
            end else begin
                mon_e = wq.pop_front();
                chk("last_width", last_width, mon_e.w);
                chk("glitch", glitch, mon_e.g);
            end
        end
        if (chk_count && count_valid) begin
            if (cq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL count_unexpected pulse_count=%0d required=no_event", pulse_count);
            end else begin
                mon_c = cq.pop_front();
                chk("pulse_count", pulse_count, mon_c);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{1,  4, 8'd1,  1'b1};
        vecs[1] = '{2,  4, 8'd2,  1'b0};
        vecs[2] = '{3,  5, 8'd3,  1'b0};
        vecs[3] = '{7,  3, 8'd7,  1'b0};
        vecs[4] = '{1,  3, 8'd1,  1'b1};
        vecs[5] = '{20, 6, 8'd20, 1'b0};

        // Reset state
        clear    = 1'b0;
        enable   = 1'b1;
        pulse_in = 1'b0;
        #1;
        chk("rst_rise", rise, 0);
        chk("rst_pulse_count", pulse_count, 0);
        chk("rst_last_width", last_width, 0);
        chk("rst_timeout", timeout, 0);
        repeat (3) tick();
        chk("rst_count_valid", count_valid, 0);
        chk("rst_width_valid", width_valid, 0);

        // Timeout and first window after release
        clear = 1'b1;
        repeat (31) tick();
        chk("timeout_before_32", timeout, 0);
        tick();
        chk("timeout_at_32", timeout, 1);
        repeat (31) tick();
        chk("first_win_not_yet", count_valid, 0);
        tick();
        chk("first_win_valid", count_valid, 1);
        chk("first_win_count", pulse_count, 0);
        chk("timeout_held", timeout, 1);
        pulse_in = 1'b1;
        repeat (2) tick();
        chk("rise_latency_early", rise, 0);
        chk("timeout_before_rise", timeout, 1);
        tick();
        chk("rise_latency", rise, 1);
        chk("timeout_cleared_by_rise", timeout, 0);
        pulse_in = 1'b0;
        repeat (8) tick();

        // Table-driven widths and glitches
        chk_width = 1'b1;
        for (int i = 0; i < 6; i++) begin
            wq.push_back('{vecs[i].exp_w, vecs[i].exp_g});
            drive_pulse(vecs[i].hi, vecs[i].lo);
        end
        repeat (4) tick();
        chk("table_width_queue_empty", wq.size(), 0);
        chk_width = 1'b0;

        // Window count, then asynchronous reset mid-window with acc=5
        do_reset();
        repeat (10) drive_pulse(3, 3);
        repeat (4) tick();
        repeat (5) drive_pulse(3, 3);
        chk("pre_reset_pulse_count", pulse_count, 10);
        chk("pre_reset_last_width", last_width, 3);
        #2;
        clear = 1'b0;
        #1;
        chk("async_rst_pulse_count", pulse_count, 0);
        chk("async_rst_last_width", last_width, 0);
        chk("async_rst_timeout", timeout, 0);
        chk("async_rst_strobes", {rise, count_valid, width_valid, glitch}, 0);
        tick();

        // Period train 3 high / 5 low
        clear = 1'b1;
        chk_width = 1'b1;
        chk_count = 1'b1;
        cq.push_back(16'd8);
        cq.push_back(16'd8);
        for (int i = 0; i < 16; i++) begin
            wq.push_back('{8'd3, 1'b0});
            drive_pulse(3, 5);
        end
        repeat (6) tick();
        chk("train_width_queue_empty", wq.size(), 0);
        chk("train_count_queue_empty", cq.size(), 0);

        // Window boundary: rises at edges 22, 63 | 102 | 128, 152
        do_reset();
        cq.push_back(16'd2);
        cq.push_back(16'd1);
        cq.push_back(16'd2);
        for (int i = 0; i < 5; i++) wq.push_back('{8'd1, 1'b1});
        for (int c = 0; c < 192; c++) begin
            pulse_in = (c == 20 || c == 61 || c == 100 || c == 126 || c == 150);
            tick();
        end
        pulse_in = 1'b0;
        repeat (4) tick();
        chk("boundary_width_queue_empty", wq.size(), 0);
        chk("boundary_count_queue_empty", cq.size(), 0);
        chk_width = 1'b0;
        chk_count = 1'b0;

        // enable=0 while pulsing
        chk("timeout_before_disable", timeout, 1);
        enable = 1'b0;
        rises  = 0;
        for (int i = 0; i < 12; i++) begin
            pulse_in = ((i % 4) < 2);
            tick();
            if (rise) rises++;
            chk("dis_count_valid", count_valid, 0);
            chk("dis_width_valid", width_valid, 0);
            chk("dis_timeout", timeout, 0);
        end
        pulse_in = 1'b0;
        repeat (4) tick();
        chk("dis_rise_count", rises, 3);
        chk("dis_pulse_count_held", pulse_count, 2);
        chk("dis_last_width_held", last_width, 1);

        // Re-enable with a 300-cycle high pulse: window restart and width saturation
        chk_width = 1'b1;
        chk_count = 1'b1;
        cq.push_back(16'd1);
        cq.push_back(16'd0);
        cq.push_back(16'd0);
        cq.push_back(16'd0);
        wq.push_back('{8'd255, 1'b0});
        enable = 1'b1;
        drive_pulse(300, 10);
        chk("sat_width_queue_empty", wq.size(), 0);
        chk("sat_count_queue_empty", cq.size(), 0);
        chk("sat_last_width", last_width, 255);
        chk_width = 1'b0;
        chk_count = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
